// File: rtl/sub_bytes_stage.sv
// sub_bytes_stage: AES SubBytes over a 128-bit state, LANES bytes per clock, S-box computed in GF(2^8).
// Define SBYTES_INV_EN to compile in the inverse S-box, selected by the `inverse` value captured at start.
module sub_bytes_stage #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         sbytes_enable,
   input  logic         inverse,
   input  logic [127:0] state_in,
   output logic [127:0] state_out,
   output logic         sbytes_finished,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   // Handshake: sbytes_enable is a start request that is only accepted in IDLE (never queued);
   // sbytes_finished is a one-cycle pulse during which state_out holds the complete result.

   localparam int CHUNKS = 16 / LANES;
   localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $fatal(1, "sub_bytes_stage: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } fsm_t;

   fsm_t             state_q;
   fsm_t             state_d;
   logic [127:0]     data_q;
   logic [127:0]     data_d;
   logic [IDX_W-1:0] idx_q;
   logic             last_chunk;
   int               lane_pos;

   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse and maps 0 to 0 without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

`ifdef SBYTES_INV_EN
   logic inv_q;

   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   // One GF inverter per lane is shared by both directions; only the affine step moves.
   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      logic [7:0] g;
      g = gf_inv(inv ? inv_affine(b) : b);
      return inv ? g : affine(g);
   endfunction

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         inv_q <= 1'b0;
      end else if (state_q == IDLE && sbytes_enable) begin
         inv_q <= inverse;
      end
   end
`else
   logic inv_q;
   logic unused_inverse;

   assign inv_q          = 1'b0;
   assign unused_inverse = inverse;

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      return inv ? affine(gf_inv(b)) : affine(gf_inv(b));
   endfunction
`endif

   assign last_chunk = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sbytes_enable) state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Substitute the current chunk of LANES bytes; byte 0 sits in the MSB position.
   always_comb begin
      data_d   = data_q;
      lane_pos = 0;
      for (int l = 0; l < LANES; l++) begin
         lane_pos = (int'(idx_q) * LANES + l) * 8;
         data_d[127 - lane_pos -: 8] = sub_byte(data_q[127 - lane_pos -: 8], inv_q);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_q <= '0;
         idx_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sbytes_enable) begin
                  data_q <= state_in;
                  idx_q  <= '0;
               end
            end
            RUN: begin
               data_q <= data_d;
               idx_q  <= last_chunk ? '0 : idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state_out       = data_q;
   assign sbytes_finished = (state_q == DONE);
   assign busy            = (state_q == RUN) || (state_q == DONE);
   assign dbg_state       = state_q;

endmodule

// File: doc/sub_bytes_stage.md
# sub_bytes_stage

Parametrised AES SubBytes stage for the cipher datapath. Takes a 128-bit state on an `sbytes_enable` pulse and substitutes every byte through the AES S-box, processing `LANES` bytes per clock. When all 16 bytes are done it pulses `sbytes_finished` for one cycle. It sits between the round controller and the ShiftRows stage and uses the same enable/finished handshake as the other round stages.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16; any other value is a fatal elaboration error.
- `clk` input 1: sole clock, rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `sbytes_enable` input 1: start request, sampled in IDLE only.
- `inverse` input 1: 0 selects the forward S-box, 1 selects the inverse S-box. Captured with the start. Honoured only when `SBYTES_INV_EN` is defined.
- `state_in` input 128: input state. Byte i is `state_in[127-8i -: 8]`, so byte 0 is the MSB byte.
- `state_out` output 128: working/result register, with the same byte order as `state_in`.
- `sbytes_finished` output 1: one-cycle pulse; `state_out` holds the full result while it is high.
- `busy` output 1: high in RUN and DONE.

## Operation
- FSM states:
  - IDLE: wait for `sbytes_enable`.
  - RUN: substitute bytes, `LANES` per cycle.
  - DONE: pulse `sbytes_finished`.
- Byte counter `idx`: width `$clog2(16/LANES)`, minimum 1 bit, counts chunks.
- IDLE:
  - `sbytes_enable=1` at an edge: load `state_in` into the register, latch `inverse`, clear `idx`, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Bytes `idx*LANES` through `idx*LANES+LANES-1` of the register are replaced by `S(byte)`, or by `InvS(byte)` if the latched mode is inverse.
  - `idx` then increments.
  - On the edge that processes the last chunk (`idx == 16/LANES-1`), go to DONE.
- DONE: `sbytes_finished=1` for exactly one cycle, then unconditionally return to IDLE.
- `sbytes_enable` in RUN or DONE is ignored. It is not queued; the requester must wait for `sbytes_finished`.
- `state_in` and `inverse` are don't-care outside the IDLE start edge. Changes during RUN have no effect.
- `state_out` holds the result after DONE until the next start edge overwrites it. During RUN it is partially substituted and not valid.
- S-box:
  - Forward: multiplicative inverse in GF(2^8) (polynomial 0x11B, with inv(0)=0), then the FIPS-197 affine transform (constant 0x63).
  - Inverse: the inverse affine transform (constant 0x05), then the GF inverse.
  - Pure combinational function, replicated `LANES` times.
  - No table ROM.
- Illegal FSM encodings recover to IDLE on the next edge with outputs deasserted.

## Timing
- Reset values: `state_out=0`, `sbytes_finished=0`, `busy=0`, FSM=IDLE, `idx=0`.
- Reset asserted mid-operation: everything returns to reset values immediately and the operation is abandoned. No `sbytes_finished` is produced.
- Latency:
  - Start edge at cycle 0.
  - `sbytes_finished` is high during cycle `16/LANES + 1`.
  - For `LANES=16` this is cycle 2; for `LANES=1`, cycle 17.
- Throughput: one block per `16/LANES + 2` cycles. The earliest next start is the edge ending the `sbytes_finished` cycle plus one, because IDLE must be re-entered first.
- `busy` rises at cycle 1, the first cycle after the start edge, and falls in the cycle after `sbytes_finished`.
- Outputs are registered or decoded from FSM state only; there is no combinational path from any input to any output.

## Configuration
- `SBYTES_INV_EN` defined:
  - The inverse S-box logic is compiled in.
  - The latched `inverse=1` selects `InvS`.
- `SBYTES_INV_EN` undefined:
  - The inverse logic and the mode latch are removed.
  - The `inverse` port remains but is ignored; every operation uses the forward S-box.

## Test plan
- Reset mid-RUN, `LANES=1`: assert `n_rst=0` at cycle 5 → `state_out=0`, `busy=0`, no `sbytes_finished` pulse. A new start afterwards completes normally.
- FIPS-197 vector, `LANES=4`, `inverse=0`: `state_in=193de3bea0f4e22b9ac68d2ae9f84808` → `sbytes_finished` high at cycle 5, `state_out=d42711aee0bf98f1b8b45de51e415230`.
- All-zero and single-byte checks, `LANES=16`:
  - `state_in=0` → `state_out=63636363...63`, finished at cycle 2.
  - Byte0=`0x53`, others `0x01` → byte0=`0xED`, others `0x7C`.
- Inverse, `SBYTES_INV_EN` defined, `LANES=2`, `inverse=1`: `state_in=d42711aee0bf98f1b8b45de51e415230` → `state_out=193de3bea0f4e22b9ac68d2ae9f84808`, finished at cycle 9.
- Inverse ignored, `SBYTES_INV_EN` undefined: `inverse=1`, `state_in=0` → `state_out=6363...63`.
- Handshake:
  - Hold `sbytes_enable=1` continuously with `LANES=8` → finished pulses every 4 cycles.
  - Each pulse lasts exactly one cycle.
  - Changing `state_in` during RUN does not alter the result.
